// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller and the display driver:
// state codes, product codes, price table and coin decode.
package vend_pkg;

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_PRODSEL = 3'd1,
    S_AMTSEL  = 3'd2,
    S_DISP    = 3'd3,
    S_CHNG    = 3'd4,
    S_REFUND  = 3'd5,
    S_STOCK   = 3'd6
  } state_t;

  localparam logic [3:0] PROD_A = 4'hA;
  localparam logic [3:0] PROD_B = 4'hB;
  localparam logic [3:0] PROD_C = 4'hC;
  localparam logic [3:0] PROD_D = 4'hD;
  localparam logic [3:0] PROD_E = 4'hE;
  localparam int         NUM_PROD = 5;

  // Fixed price table; unknown codes price at 0.
  function automatic logic [3:0] prod_price(input logic [3:0] prod);
    case (prod)
      PROD_A:  return 4'd5;
      PROD_B:  return 4'd8;
      PROD_C:  return 4'd10;
      PROD_D:  return 4'd12;
      PROD_E:  return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  // Product rotation A->B->C->D->E->A; anything unexpected restarts at A.
  function automatic logic [3:0] prod_next(input logic [3:0] prod);
    case (prod)
      PROD_A:  return PROD_B;
      PROD_B:  return PROD_C;
      PROD_C:  return PROD_D;
      PROD_D:  return PROD_E;
      default: return PROD_A;
    endcase
  endfunction

  // Coin code to value: 00=1, 01=2, 10=5, 11=10.
  function automatic logic [3:0] coin_value(input logic [1:0] code);
    case (code)
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd5;
      default: return 4'd10;
    endcase
  endfunction

  // Credit addition saturating at 15 so the 4-bit display value never wraps.
  function automatic logic [3:0] money_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 5'd15) ? 4'd15 : s[3:0];
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter shared by the dwell and idle-timeout uses.
// done is high during the cycle in which the count is 1, so a load of N
// makes the owning state exit exactly N edges after the load edge.
module vend_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] r_cnt;

  // Count down to zero and park there; load wins over the decrement.
  always_ff @(posedge clk) begin
    if (rst || clear) r_cnt <= '0;
    else if (load)    r_cnt <= load_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign done = (r_cnt == W'(1));

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine control FSM feeding the seven-segment display driver.
// Holds state, selected product/price, credit, per-product stock and LEDs.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int STOCK_INIT = 3,
  parameter int DWELL      = 2000,
  parameter int TIMEOUT    = 10000
) (
  input  logic       clk_1ms,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_sel,
  input  logic       btn_cancel,
  input  logic       coin_valid,
  input  logic [1:0] coin_val,
  input  logic       restock,
  output logic [2:0] ps,
  output logic [3:0] CurrProd,
  output logic [3:0] CurrPrice,
  output logic [3:0] money,
  output logic [3:0] LED
);

  localparam int TMAX = (DWELL > TIMEOUT) ? DWELL : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  state_t                     r_ps, w_ns;
  logic [3:0]                 r_prod, w_prod_nxt, r_price, r_money, w_money_nxt, r_led;
  logic [NUM_PROD-1:0][1:0]   r_stock;
  logic [3:0]                 w_off, w_coin_sum;
  logic [2:0]                 w_idx;
  logic                       w_prod_ok;
  logic [1:0]                 w_stock_cur;
  logic                       w_dec, w_restock;
  logic                       w_tmr_load, w_tmr_clear, w_tmr_done;
  logic [TW-1:0]              w_tmr_val;

  assign w_off       = r_prod - PROD_A;
  assign w_idx       = w_off[2:0];
  assign w_prod_ok   = (r_prod >= PROD_A) && (r_prod <= PROD_E);
  assign w_stock_cur = w_prod_ok ? r_stock[w_idx] : 2'd0;
  assign w_coin_sum  = money_add(r_money, coin_value(coin_val));

  vend_timer #(.W(TW)) u_timer (
    .clk      (clk_1ms),
    .rst      (rst),
    .load     (w_tmr_load),
    .clear    (w_tmr_clear),
    .load_val (w_tmr_val),
    .done     (w_tmr_done)
  );

  // Next-state, product, credit and stock-update decisions.
  always_comb begin
    w_ns        = r_ps;
    w_prod_nxt  = r_prod;
    w_money_nxt = r_money;
    w_dec       = 1'b0;
    w_restock   = 1'b0;
    case (r_ps)
      S_RESET: begin
        w_restock = restock;
        if (btn_sel) w_ns = S_PRODSEL;
      end
      S_PRODSEL: begin
        if (btn_cancel) w_ns = S_RESET;
        else if (btn_sel) begin
          if (w_stock_cur == 2'd0) w_ns = S_STOCK;
          else begin
            w_ns        = S_AMTSEL;
            w_money_nxt = '0;
          end
        end else if (btn_next) w_prod_nxt = prod_next(r_prod);
      end
      S_AMTSEL: begin
        // Cancel still credits a same-cycle coin and beats the vend.
        if (btn_cancel) begin
          w_money_nxt = coin_valid ? w_coin_sum : r_money;
          w_ns        = (w_money_nxt != '0) ? S_REFUND : S_RESET;
        end else if (coin_valid) begin
          w_money_nxt = w_coin_sum;
          if (w_coin_sum >= r_price) begin
            w_ns  = S_DISP;
            w_dec = 1'b1;
          end
        end else if (w_tmr_done) begin
          w_ns = (r_money != '0) ? S_REFUND : S_RESET;
        end
      end
      S_DISP:   if (w_tmr_done) w_ns = (r_money > r_price) ? S_CHNG : S_RESET;
      S_CHNG:   if (w_tmr_done) w_ns = S_RESET;
      S_REFUND: if (w_tmr_done) w_ns = S_RESET;
      S_STOCK:  if (w_tmr_done) w_ns = S_PRODSEL;
      default:  w_ns = S_RESET;
    endcase
    if (w_ns == S_RESET) w_money_nxt = '0;
  end

  // Timer arms on entry to a timed state and re-arms on every AmtSel coin.
  always_comb begin
    w_tmr_load  = ((w_ns != r_ps) &&
                   (w_ns inside {S_AMTSEL, S_DISP, S_CHNG, S_REFUND, S_STOCK})) ||
                  ((r_ps == S_AMTSEL) && (w_ns == S_AMTSEL) && coin_valid);
    w_tmr_val   = (w_ns == S_AMTSEL) ? TW'(TIMEOUT) : TW'(DWELL);
    w_tmr_clear = !w_tmr_load && (w_ns inside {S_RESET, S_PRODSEL});
  end

  // Registered state and display-facing outputs.
  always_ff @(posedge clk_1ms) begin
    if (rst) begin
      r_ps    <= S_RESET;
      r_prod  <= PROD_A;
      r_price <= prod_price(PROD_A);
      r_money <= '0;
      r_led   <= '0;
    end else begin
      r_ps    <= w_ns;
      r_prod  <= w_prod_nxt;
      r_price <= prod_price(w_prod_nxt);
      r_money <= w_money_nxt;
      r_led   <= {w_ns == S_STOCK, w_ns == S_REFUND, w_ns == S_CHNG, w_ns == S_DISP};
    end
  end

  // Per-product stock: refill in Reset, saturating decrement on each vend.
  always_ff @(posedge clk_1ms) begin
    if (rst || w_restock)
      r_stock <= {NUM_PROD{2'(STOCK_INIT)}};
    else if (w_dec && w_prod_ok && (w_stock_cur != 2'd0))
      r_stock[w_idx] <= w_stock_cur - 2'd1;
  end

  assign ps        = r_ps;
  assign CurrProd  = r_prod;
  assign CurrPrice = r_price;
  assign money     = r_money;
  assign LED       = r_led;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed vector table, hand-written corner sequences,
// then random pulses checked against a rule-level model of the machine.
module tb_vend_ctrl;

  localparam int DW = 4;
  localparam int TO = 10;
  localparam int SI = 3;

  logic       clk_1ms = 1'b0;
  logic       rst = 1'b0, btn_next = 1'b0, btn_sel = 1'b0, btn_cancel = 1'b0;
  logic       coin_valid = 1'b0, restock = 1'b0;
  logic [1:0] coin_val = 2'b00;
  logic [2:0] ps;
  logic [3:0] CurrProd, CurrPrice, money, LED;

  int errors = 0;
  int checks = 0;

  vend_ctrl #(.STOCK_INIT(SI), .DWELL(DW), .TIMEOUT(TO)) dut (
    .clk_1ms    (clk_1ms),
    .rst        (rst),
    .btn_next   (btn_next),
    .btn_sel    (btn_sel),
    .btn_cancel (btn_cancel),
    .coin_valid (coin_valid),
    .coin_val   (coin_val),
    .restock    (restock),
    .ps         (ps),
    .CurrProd   (CurrProd),
    .CurrPrice  (CurrPrice),
    .money      (money),
    .LED        (LED)
  );

  always #5 clk_1ms = ~clk_1ms;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int e_ps, input int e_prod, input int e_price,
                         input int e_money, input int e_led);
    chk({nm, ".ps"},    32'(ps),        e_ps);
    chk({nm, ".prod"},  32'(CurrProd),  e_prod);
    chk({nm, ".price"}, 32'(CurrPrice), e_price);
    chk({nm, ".money"}, 32'(money),     e_money);
    chk({nm, ".led"},   32'(LED),       e_led);
  endtask

  // One clock: drive pulses, let the edge take them, sample 1 time unit later.
  task automatic cyc(input bit n, input bit s, input bit c, input bit cv,
                     input bit [1:0] cval, input bit rs, input bit r);
    btn_next = n; btn_sel = s; btn_cancel = c; coin_valid = cv;
    coin_val = cval; restock = rs; rst = r;
    @(posedge clk_1ms); #1;
    btn_next = 0; btn_sel = 0; btn_cancel = 0; coin_valid = 0;
    coin_val = 0; restock = 0; rst = 0;
  endtask

  task automatic idle(input int k);  repeat (k) cyc(0,0,0,0,0,0,0); endtask
  task automatic sel();              cyc(0,1,0,0,0,0,0); endtask
  task automatic nxt();              cyc(1,0,0,0,0,0,0); endtask
  task automatic cnc();              cyc(0,0,1,0,0,0,0); endtask
  task automatic coin(input bit [1:0] c); cyc(0,0,0,1,c,0,0); endtask
  task automatic do_rst();           cyc(0,0,0,0,0,0,1); endtask

  // ---------------- reference model (rule level) ----------------
  int price_tab[5] = '{5, 8, 10, 12, 15};
  int coin_tab[4]  = '{1, 2, 5, 10};
  int m_st, m_prod, m_money, m_since;
  int m_stock[5];

  task automatic model_step(input bit n, input bit s, input bit c, input bit cv,
                            input bit [1:0] cval, input bit rs, input bit r);
    int ns, nm, tot;
    if (r) begin
      m_st = 0; m_prod = 0; m_money = 0; m_since = 0;
      foreach (m_stock[k]) m_stock[k] = SI;
      return;
    end
    ns = m_st; nm = m_money;
    case (m_st)
      0: begin
        if (rs) foreach (m_stock[k]) m_stock[k] = SI;
        if (s) ns = 1;
      end
      1: begin
        if (c) ns = 0;
        else if (s) begin
          if (m_stock[m_prod] == 0) ns = 6;
          else begin ns = 2; nm = 0; end
        end else if (n) m_prod = (m_prod + 1) % 5;
      end
      2: begin
        tot = m_money + (cv ? coin_tab[cval] : 0);
        if (tot > 15) tot = 15;
        if (c) begin nm = tot; ns = (tot > 0) ? 5 : 0; end
        else if (cv) begin
          nm = tot;
          if (tot >= price_tab[m_prod]) begin
            ns = 3;
            if (m_stock[m_prod] > 0) m_stock[m_prod]--;
          end
        end else if (m_since + 1 == TO) ns = (m_money > 0) ? 5 : 0;
      end
      3: if (m_since + 1 == DW) ns = (m_money > price_tab[m_prod]) ? 4 : 0;
      4, 5: if (m_since + 1 == DW) ns = 0;
      6: if (m_since + 1 == DW) ns = 1;
      default: ns = 0;
    endcase
    if (ns == 0) nm = 0;
    m_since = ((ns != m_st) || (m_st == 2 && cv)) ? 0 : m_since + 1;
    m_st = ns; m_money = nm;
  endtask

  function automatic int model_led();
    case (m_st)
      3: return 1;
      4: return 2;
      5: return 4;
      6: return 8;
      default: return 0;
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit n, s, c, cv; bit [1:0] cval; bit rs, r;
    int e_ps, e_prod, e_price, e_money, e_led;
  } vec_t;
  vec_t tv[$];

  initial begin
    // inputs: next sel cancel cv cval restock rst | ps prod price money led
    tv.push_back(vec_t'{0,0,0,0,2'd0,0,1, 0,10, 5,0,0});  // reset values
    tv.push_back(vec_t'{0,1,0,0,2'd0,0,0, 1,10, 5,0,0});
    tv.push_back(vec_t'{1,0,0,0,2'd0,0,0, 1,11, 8,0,0});
    tv.push_back(vec_t'{1,0,0,0,2'd0,0,0, 1,12,10,0,0});  // C, price 10
    tv.push_back(vec_t'{0,0,1,0,2'd0,0,0, 0,12,10,0,0});
    tv.push_back(vec_t'{0,0,0,0,2'd0,0,1, 0,10, 5,0,0});
    tv.push_back(vec_t'{0,1,0,0,2'd0,0,0, 1,10, 5,0,0});
    tv.push_back(vec_t'{1,0,0,0,2'd0,0,0, 1,11, 8,0,0});
    tv.push_back(vec_t'{0,1,0,0,2'd0,0,0, 2,11, 8,0,0});
    tv.push_back(vec_t'{0,0,0,1,2'd2,0,0, 2,11, 8,5,0});  // +5
    tv.push_back(vec_t'{0,0,0,1,2'd1,0,0, 2,11, 8,7,0});  // +2
    tv.push_back(vec_t'{0,0,0,1,2'd0,0,0, 3,11, 8,8,1});  // +1 -> Disp
    tv.push_back(vec_t'{0,0,0,0,2'd0,0,0, 3,11, 8,8,1});
    tv.push_back(vec_t'{0,0,0,0,2'd0,0,0, 3,11, 8,8,1});
    tv.push_back(vec_t'{0,0,0,0,2'd0,0,0, 3,11, 8,8,1});
    tv.push_back(vec_t'{0,0,0,0,2'd0,0,0, 0,11, 8,0,0});  // DWELL done -> Reset

    #2;
    foreach (tv[i]) begin
      cyc(tv[i].n, tv[i].s, tv[i].c, tv[i].cv, tv[i].cval, tv[i].rs, tv[i].r);
      chk_all($sformatf("vec%0d", i), tv[i].e_ps, tv[i].e_prod, tv[i].e_price,
              tv[i].e_money, tv[i].e_led);
    end

    // Change: A with a 10-coin, Disp then Chng.
    do_rst(); sel(); sel();
    coin(2'd3);     chk_all("chg_disp", 3, 10, 5, 10, 1);
    idle(DW - 1);   chk_all("chg_disp_hold", 3, 10, 5, 10, 1);
    idle(1);        chk_all("chg_enter", 4, 10, 5, 10, 2);
    chk("chg_amount", 32'(money - CurrPrice), 5);
    idle(DW - 1);   chk_all("chg_hold", 4, 10, 5, 10, 2);
    idle(1);        chk_all("chg_exit", 0, 10, 5, 0, 0);

    // Refund: E, coin 5, then cancel with a same-cycle 2-coin.
    do_rst(); sel(); repeat (4) nxt();
    chk_all("ref_prodE", 1, 14, 15, 0, 0);
    sel(); coin(2'd2);  chk_all("ref_m5", 2, 14, 15, 5, 0);
    cyc(0,0,1,1,2'd1,0,0);  chk_all("ref_enter", 5, 14, 15, 7, 4);
    idle(DW - 1);   chk_all("ref_hold", 5, 14, 15, 7, 4);
    idle(1);        chk_all("ref_exit", 0, 14, 15, 0, 0);

    // Sold out: buy A three times, fourth selection lands in Stock.
    do_rst();
    repeat (3) begin
      sel(); sel(); coin(2'd2);
      chk_all("buyA_disp", 3, 10, 5, 5, 1);
      idle(DW);
    end
    sel(); sel();   chk_all("stk_enter", 6, 10, 5, 0, 8);
    idle(DW - 1);   chk_all("stk_hold", 6, 10, 5, 0, 8);
    idle(1);        chk_all("stk_exit", 1, 10, 5, 0, 0);
    cnc(); cyc(0,0,0,0,0,1,0);
    sel(); sel();   chk_all("restock_amt", 2, 10, 5, 0, 0);

    // Idle timeout with no credit -> Reset.
    idle(TO - 1);   chk_all("to0_hold", 2, 10, 5, 0, 0);
    idle(1);        chk_all("to0_exit", 0, 10, 5, 0, 0);
    // Idle timeout with credit 1 -> Refund, timer restarted by the coin.
    sel(); sel(); idle(3); coin(2'd0);
    idle(TO - 1);   chk_all("to1_hold", 2, 10, 5, 1, 0);
    idle(1);        chk_all("to1_exit", 5, 10, 5, 1, 4);
    idle(DW);       chk("to1_done", 32'(ps), 0);

    // Cancel in AmtSel with no credit -> Reset.
    sel(); sel(); cnc(); chk_all("cnc0", 0, 10, 5, 0, 0);

    // Saturation: E with 10 + 10 -> 15 and vend; then rst mid-Disp.
    sel(); repeat (4) nxt(); sel();
    coin(2'd3);     chk_all("sat_10", 2, 14, 15, 10, 0);
    coin(2'd3);     chk_all("sat_15", 3, 14, 15, 15, 1);
    idle(1); do_rst();
    chk_all("rst_mid_disp", 0, 10, 5, 0, 0);

    // Random pulses against the model.
    do_rst();
    model_step(0,0,0,0,0,0,1);
    for (int i = 0; i < 3000; i++) begin
      bit n, s, c, cv, rs, r;
      bit [1:0] cval;
      n = ($urandom % 4) == 0;  s = ($urandom % 4) == 0;
      c = ($urandom % 16) == 0; cv = ($urandom % 3) == 0;
      cval = 2'($urandom); rs = ($urandom % 8) == 0;
      r = ($urandom % 400) == 0;
      cyc(n, s, c, cv, cval, rs, r);
      model_step(n, s, c, cv, cval, rs, r);
      chk_all($sformatf("rnd%0d", i), m_st, 10 + m_prod, price_tab[m_prod],
              m_money, model_led());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Vending-machine control FSM that sits directly upstream of the seven-segment display driver. It turns debounced button and coin pulses into the machine state code, selected product, product price, credited money and status LEDs that the display stage renders. It also holds per-product stock counts and times the display dwell periods.

## Interface
- STOCK_INIT, default 3: units per product after reset or restock (2-bit counters, max 3).
- DWELL, default 2000: cycles spent in Disp, Chng, Refund and Stock before advancing (2 s at 1 ms clock).
- TIMEOUT, default 10000: idle cycles in AmtSel before auto-exit.

- clk_1ms  in  1  system clock; same 1 ms clock as the display driver.
- rst  in  1  synchronous, active-high reset.
- btn_next  in  1  one-cycle pulse; advance product.
- btn_sel  in  1  one-cycle pulse; start or confirm selection.
- btn_cancel  in  1  one-cycle pulse; abort.
- coin_valid  in  1  one-cycle pulse; coin inserted.
- coin_val  in  2  coin code, sampled with coin_valid: 00=1, 01=2, 10=5, 11=10.
- restock  in  1  one-cycle pulse; refill all stock. Honoured only in Reset.
- ps  out  3  state code: Reset=0, ProdSel=1, AmtSel=2, Disp=3, Chng=4, Refund=5, Stock=6.
- CurrProd  out  4  product code, 4'hA..4'hE.
- CurrPrice  out  4  price of CurrProd.
- money  out  4  credited amount, saturating at 15.
- LED  out  4  status LEDs: [0] vending, [1] change due, [2] refund, [3] sold out.

## Operation
- Price table, fixed: A=5, B=8, C=10, D=12, E=15. CurrPrice is always the price of CurrProd, updated on the same edge as CurrProd.
- **Reset**
  - btn_sel goes to ProdSel.
  - restock sets all five stock counters to STOCK_INIT.
  - Other inputs are ignored.
- **ProdSel**
  - btn_next steps A→B→C→D→E→A.
  - btn_sel with stock[CurrProd]==0 goes to Stock.
  - btn_sel with stock>0 goes to AmtSel with money=0.
  - btn_cancel goes to Reset.
  - Same-cycle priority: cancel > sel > next.
- **AmtSel**
  - On coin_valid: money_next = min(money + value, 15).
  - If money_next ≥ CurrPrice: go to Disp and decrement stock[CurrProd].
  - btn_cancel: a same-cycle coin is still credited. Then go to Refund if money_next > 0, else Reset. Cancel beats vend.
  - Idle timer counts cycles without a coin; a coin resets it. When it reaches TIMEOUT: Refund if money > 0, else Reset.
  - Invariant: money < CurrPrice while in AmtSel, so the display's CurrPrice−money never underflows.
- **Disp**: after DWELL cycles, go to Chng if money > CurrPrice, else to Reset with money cleared.
- **Chng**: after DWELL cycles, go to Reset and clear money.
- **Refund**: after DWELL cycles, go to Reset and clear money.
- **Stock**: after DWELL cycles, return to ProdSel. CurrProd is unchanged.
- Buttons other than btn_cancel are ignored in Disp, Chng and Stock. btn_cancel is ignored in Disp, Chng, Refund and Stock.
- LED is a registered decode of state:
  - LED[0] = Disp.
  - LED[1] = Chng.
  - LED[2] = Refund.
  - LED[3] = Stock.
- Illegal state codes recover to Reset on the next edge.

## Timing
- All outputs are registered. Each input pulse takes effect one edge after it is sampled.
- Reset values:
  - ps=0
  - CurrProd=4'hA
  - CurrPrice=4'h5
  - money=0
  - LED=0
  - all stock=STOCK_INIT
  - timers=0
- Dwell states last exactly DWELL cycles, counted from the entry edge.
- The idle timeout fires on cycle TIMEOUT after the last coin or after AmtSel entry.
- rst asserted mid-vend aborts with no refund accounting. Stock already decremented stays decremented.
- Stock decrement saturates at 0.

## Structure
- Shared package vend_pkg holds:
  - state codes, which the display driver must also use;
  - product codes 4'hA..4'hE;
  - the price table function;
  - the coin-decode function.
- One sub-module, vend_timer: loadable down-counter, width $clog2(max(DWELL,TIMEOUT)+1), with load/clear inputs and a done pulse. It is shared by the dwell and idle uses, which are mutually exclusive by state.

## Test plan
- Reset, then btn_sel, then btn_next ×2 → ps=1, CurrProd=C, CurrPrice=10.
- Product B; coins 5, 2, 1 → money 5, 7, 8. Disp on the third coin. stock[B] 3→2. After DWELL → Reset, money=0.
- Product A; coin 10 → Disp (money=10). After DWELL → Chng with money−price=5 and LED=4'b0010. After DWELL → Reset.
- Product E; coin 5, then btn_cancel in the same cycle as a 2-coin → Refund, money=7, LED=4'b0100.
- Buy A three times; fourth btn_sel on A → Stock, LED[3]=1. After DWELL → ProdSel, CurrProd=A. restock in Reset → next selection of A reaches AmtSel.
- AmtSel with no coins for TIMEOUT cycles → Reset. Separately, one 1-coin then idle → Refund, money=1. rst mid-Disp → all reset values next edge.
